// File: rtl/fpga_link_pkg.sv
// Shared definitions for the FPGA-to-FPGA parallel link: word width,
// receiver state encodings and the running XOR used for burst checksums.
package fpga_link_pkg;

  localparam int LINK_W = 32;

  // Encodings overlap with the sender's IDLE/READY/ACK values.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READY   = 3'd1,
    ST_RECEIVE = 3'd2,
    ST_CHECK   = 3'd3,
    ST_ACK     = 3'd4,
    ST_ABORT   = 3'd5
  } rx_state_e;

  function automatic logic [LINK_W-1:0] link_xor(input logic [LINK_W-1:0] acc,
                                                 input logic [LINK_W-1:0] word);
    return acc ^ word;
  endfunction

endpackage

// File: rtl/fpga2_receiver_if.sv
// Link and read-port bundle for the FPGA 2 receiver.
// master = sender/consumer side, slave = receiver.
interface fpga2_receiver_if;
  logic                               req_in;
  logic [fpga_link_pkg::LINK_W-1:0]   data_in;
  logic                               rdy_out;
  logic                               ack_out;
  logic                               rd_en;
  logic [fpga_link_pkg::LINK_W-1:0]   rd_data;
  logic                               rd_valid;
  logic                               done;
  logic [7:0]                         err_count;

  modport master (
    output req_in, data_in, rd_en,
    input  rdy_out, ack_out, rd_data, rd_valid, done, err_count
  );

  modport slave (
    input  req_in, data_in, rd_en,
    output rdy_out, ack_out, rd_data, rd_valid, done, err_count
  );
endinterface

// File: rtl/rx_commit_fifo.sv
// Dual-pointer receive buffer. Burst words land behind a speculative write
// pointer; commit publishes them to the reader, rewind throws them away.
// Pointers carry one extra bit so full and empty are distinguishable.
module rx_commit_fifo import fpga_link_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [LINK_W-1:0]        wr_data,
  input  logic                     commit,
  input  logic                     rewind,
  input  logic                     rd_en,
  output logic [LINK_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   free_cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [LINK_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_spec;
  logic [AW:0]       wr_cmt;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       used;

  assign used     = wr_cmt - rd_ptr;
  assign free_cnt = (AW+1)'(DEPTH) - used;
  assign rd_valid = (wr_cmt != rd_ptr);
  // Head word is forced to zero while nothing is committed.
  assign rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

  // Storage array, written at the speculative pointer.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_spec[AW-1:0]] <= wr_data;
  end

  // Pointer updates; commit and pop on the same edge both take effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_spec <= '0;
      wr_cmt  <= '0;
      rd_ptr  <= '0;
    end else begin
      if (rewind)  wr_spec <= wr_cmt;
      else if (wr) wr_spec <= wr_spec + 1'b1;
      if (commit)  wr_cmt  <= wr_spec;
      if (rd_en && rd_valid) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/fpga2_receiver.sv
// Receive endpoint of the FPGA 1 -> FPGA 2 parallel link.
// Optional macro RECV_CHECKSUM_EN: last burst word is an XOR checksum of the
// others; it is verified in CHECK and never stored.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for req_in with room for a whole burst
// READY   | rdy_out high, counting out the capture delay
// RECEIVE | capturing one word per edge, counter RECV_COUNT-1 .. 0
// CHECK   | single cycle: commit and ACK, or ABORT on bad checksum
// ACK     | rdy_out/ack_out high until the sender drops req_in
// ABORT   | single cycle: rewind partial burst, bump err_count
module fpga2_receiver import fpga_link_pkg::*; #(
  parameter int RECV_COUNT    = 10,
  parameter int BUF_DEPTH     = 16,
  parameter int CAPTURE_DELAY = 2
) (
  input  logic             clk,
  input  logic             rst,
  fpga2_receiver_if.slave  link
);
  localparam int AW    = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(RECV_COUNT + CAPTURE_DELAY + 1);
  localparam logic [AW:0] NEED = (AW+1)'(RECV_COUNT);

  localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
  localparam logic [2:0] S_READY   = 3'(ST_READY);
  localparam logic [2:0] S_RECEIVE = 3'(ST_RECEIVE);
  localparam logic [2:0] S_CHECK   = 3'(ST_CHECK);
  localparam logic [2:0] S_ACK     = 3'(ST_ACK);
  localparam logic [2:0] S_ABORT   = 3'(ST_ABORT);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             done_r;
  logic [7:0]       err_r;
  logic             last_word;
  logic             capture;
  logic             fifo_wr;
  logic             commit;
  logic             rewind;
  logic             csum_ok;
  logic [AW:0]      free_cnt;

  assign last_word = (cnt == '0);
  assign capture   = (state == S_RECEIVE) && link.req_in;
  assign commit    = (state == S_CHECK) && csum_ok;
  assign rewind    = (state == S_ABORT);

  assign link.rdy_out   = (state == S_READY) || (state == S_RECEIVE) ||
                          (state == S_CHECK) || (state == S_ACK);
  assign link.ack_out   = (state == S_ACK);
  assign link.done      = done_r;
  assign link.err_count = err_r;

`ifdef RECV_CHECKSUM_EN
  logic [LINK_W-1:0] csum;

  assign fifo_wr = capture && !last_word;

  // Running XOR of payload words; the final word is compared against it.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum    <= '0;
      csum_ok <= 1'b0;
    end else if (state == S_READY) begin
      csum    <= '0;
      csum_ok <= 1'b0;
    end else if (capture) begin
      if (last_word) csum_ok <= (csum == link.data_in);
      else           csum    <= link_xor(csum, link.data_in);
    end
  end
`else
  assign fifo_wr = capture;
  assign csum_ok = 1'b1;
`endif

  // Burst sequencing, delay/word counter, done pulse and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      done_r <= 1'b0;
      err_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (link.req_in && (free_cnt >= NEED)) begin
            state <= S_READY;
            cnt   <= CNT_W'(CAPTURE_DELAY - 1);
          end
        end
        S_READY: begin
          if (!link.req_in) begin
            state <= S_ABORT;
          end else if (last_word) begin
            state <= S_RECEIVE;
            cnt   <= CNT_W'(RECV_COUNT - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RECEIVE: begin
          if (!link.req_in)   state <= S_ABORT;
          else if (last_word) state <= S_CHECK;
          else                cnt   <= cnt - 1'b1;
        end
        S_CHECK: state <= csum_ok ? S_ACK : S_ABORT;
        S_ACK: begin
          if (!link.req_in) begin
            state  <= S_IDLE;
            done_r <= 1'b1;
          end
        end
        S_ABORT: begin
          state <= S_IDLE;
          if (err_r != 8'hFF) err_r <= err_r + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  rx_commit_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr       (fifo_wr),
    .wr_data  (link.data_in),
    .commit   (commit),
    .rewind   (rewind),
    .rd_en    (link.rd_en),
    .rd_data  (link.rd_data),
    .rd_valid (link.rd_valid),
    .free_cnt (free_cnt)
  );
endmodule

// File: tb/tb_fpga2_receiver.sv
// Directed + randomized bench for fpga2_receiver. The reference model is a
// queue of words the receiver should have committed; a read monitor pops it.
module tb_fpga2_receiver;
  localparam int RC = 10;
  localparam int CD = 2;
  localparam int BD = 16;
`ifdef RECV_CHECKSUM_EN
  localparam int NSTORE = RC - 1;
`else
  localparam int NSTORE = RC;
`endif

  typedef logic [31:0] burst_t [RC];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   err_exp = 0;
  bit   rd_rand = 1'b0;
  logic [31:0] exp_q [$];

  fpga2_receiver_if bus();

  fpga2_receiver #(.RECV_COUNT(RC), .BUF_DEPTH(BD), .CAPTURE_DELAY(CD)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rd_rand) bus.rd_en = 1'($urandom_range(0, 1));
  endtask

  task automatic fix_sum(inout burst_t w);
`ifdef RECV_CHECKSUM_EN
    logic [31:0] x;
    x = '0;
    for (int k = 0; k < RC - 1; k++) x ^= w[k];
    w[RC-1] = x;
`endif
  endtask

  task automatic mk_seq(input int base, output burst_t w);
    for (int k = 0; k < RC; k++) w[k] = 32'(base + k);
    fix_sum(w);
  endtask

  task automatic mk_rand(output burst_t w);
    for (int k = 0; k < RC; k++) w[k] = $urandom;
    fix_sum(w);
  endtask

  // mode 0: full burst, 1: drop req_in before word 'at', 2: reset before word 'at'
  task automatic send_burst(input burst_t w, input int mode, input int at, input string tag);
    int n;
    bit ok;
    logic [31:0] x;
    bus.req_in = 1'b1;
    n = 0;
    while (bus.rdy_out !== 1'b1 && n < 120) begin cyc(); n++; end
    chk({tag, "_rdy_wait"}, bus.rdy_out, 1);
    if (bus.rdy_out !== 1'b1) begin bus.req_in = 1'b0; return; end
    for (int i = 0; i < CD + RC; i++) begin
      if (mode == 1 && i == CD + at) begin
        bus.req_in = 1'b0;
        cyc();
        chk({tag, "_abort_rdy"}, bus.rdy_out, 0);
        chk({tag, "_abort_ack"}, bus.ack_out, 0);
        cyc();
        err_exp = (err_exp < 255) ? err_exp + 1 : 255;
        chk({tag, "_err_count"}, bus.err_count, err_exp);
        return;
      end
      if (mode == 2 && i == CD + at) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.req_in = 1'b0;
        exp_q.delete();
        err_exp = 0;
        chk({tag, "_rst_rdy"}, bus.rdy_out, 0);
        chk({tag, "_rst_ack"}, bus.ack_out, 0);
        chk({tag, "_rst_done"}, bus.done, 0);
        chk({tag, "_rst_valid"}, bus.rd_valid, 0);
        chk({tag, "_rst_data"}, bus.rd_data, 0);
        chk({tag, "_rst_err"}, bus.err_count, 0);
        return;
      end
      bus.data_in = (i >= CD) ? w[i-CD] : $urandom;
      cyc();
      chk({tag, "_rdy_hold"}, bus.rdy_out, 1);
      chk({tag, "_ack_early"}, bus.ack_out, 0);
    end
    x = '0;
    for (int k = 0; k < RC - 1; k++) x ^= w[k];
`ifdef RECV_CHECKSUM_EN
    ok = (w[RC-1] == x);
`else
    ok = 1'b1;
`endif
    cyc();
    if (ok) begin
      chk({tag, "_ack_rise"}, bus.ack_out, 1);
      chk({tag, "_ack_rdy"}, bus.rdy_out, 1);
      for (int k = 0; k < NSTORE; k++) exp_q.push_back(w[k]);
      n = $urandom_range(0, 3);
      repeat (n) begin
        cyc();
        chk({tag, "_ack_hold"}, bus.ack_out, 1);
      end
      bus.req_in = 1'b0;
      cyc();
      chk({tag, "_done_pulse"}, bus.done, 1);
      chk({tag, "_ack_fall"}, bus.ack_out, 0);
      chk({tag, "_rdy_fall"}, bus.rdy_out, 0);
      cyc();
      chk({tag, "_done_once"}, bus.done, 0);
    end else begin
      chk({tag, "_bad_ack"}, bus.ack_out, 0);
      chk({tag, "_bad_rdy"}, bus.rdy_out, 0);
      cyc();
      err_exp = (err_exp < 255) ? err_exp + 1 : 255;
      chk({tag, "_bad_err"}, bus.err_count, err_exp);
      bus.req_in = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    rd_rand = 1'b0;
    bus.rd_en = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin cyc(); n++; end
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_empty"}, bus.rd_valid, 0);
    bus.rd_en = 1'b0;
  endtask

  // Read monitor: every pop must match the oldest committed model word.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_valid", bus.rd_valid, exp_q.size() != 0);
      if (bus.rd_en && bus.rd_valid && exp_q.size() > 0)
        chk("rd_data", bus.rd_data, exp_q.pop_front());
    end
  end

  initial begin
    burst_t w;
    bus.req_in  = 1'b0;
    bus.data_in = '0;
    bus.rd_en   = 1'b0;
    rst = 1'b1;
    repeat (3) cyc();
    chk("reset_rdy", bus.rdy_out, 0);
    chk("reset_ack", bus.ack_out, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_valid", bus.rd_valid, 0);
    chk("reset_data", bus.rd_data, 0);
    chk("reset_err", bus.err_count, 0);
    rst = 1'b0;
    cyc();

    // clean burst, reader always enabled
    mk_seq(1, w);
    bus.rd_en = 1'b1;
    send_burst(w, 0, 0, "clean");
    drain("clean");

    // sender drops request after four words, then resends
    bus.rd_en = 1'b0;
    send_burst(w, 1, 4, "drop4");
    repeat (3) cyc();
    chk("drop4_no_valid", bus.rd_valid, 0);
    send_burst(w, 0, 0, "resend");
    drain("resend");

`ifdef RECV_CHECKSUM_EN
    mk_seq(1, w);
    w[RC-1] = 32'h0;
    send_burst(w, 0, 0, "badsum");
    mk_seq(1, w);
    send_burst(w, 0, 0, "goodsum");
    drain("goodsum");
`endif

    // back-pressure: 8 committed words leave too little room
    mk_rand(w);
    send_burst(w, 0, 0, "fill");
    bus.rd_en = 1'b1;
    repeat (NSTORE - 8) cyc();
    bus.rd_en = 1'b0;
    bus.req_in = 1'b1;
    repeat (20) begin
      cyc();
      chk("full_rdy_low", bus.rdy_out, 0);
    end
    bus.rd_en = 1'b1;
    repeat (2) cyc();
    bus.rd_en = 1'b0;
    cyc();
    chk("full_rdy_rise", bus.rdy_out, 1);
    mk_rand(w);
    send_burst(w, 0, 0, "after_pop");
    drain("after_pop");

    // randomized bursts with concurrent random reads
    rd_rand = 1'b1;
    for (int b = 0; b < 8; b++) begin
      mk_rand(w);
      if ($urandom_range(0, 2) == 0)
        send_burst(w, 1, int'($urandom_range(0, RC - 1)), "rand_drop");
      else
        send_burst(w, 0, 0, "rand");
    end
    drain("rand");

    // reset in the middle of a burst, then a fresh burst
    mk_seq(100, w);
    send_burst(w, 2, 5, "midrst");
    bus.rd_en = 1'b1;
    repeat (3) cyc();
    chk("midrst_empty", bus.rd_valid, 0);
    mk_seq(200, w);
    send_burst(w, 0, 0, "post_rst");
    drain("post_rst");

    // saturating error counter
    for (int b = 0; b < 260; b++) begin
      mk_rand(w);
      send_burst(w, 1, int'($urandom_range(0, RC)) - 1, "sat");
    end
    chk("sat_final", bus.err_count, 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
